// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller for the multi-cycle core: issues a registered one-cycle
// clock-enable pulse in free-run (prescaled), single-step (debounced button) or halted mode.
`timescale 1ns/1ps

module cpu_clk_ctrl #(
  parameter int DIV_WIDTH  = 20,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic [1:0]  div_sel,
  input  logic        halt_req,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [31:0] cycle_count
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t               state_q;
  logic                 run_meta, run_s;
  logic                 step_meta, step_s;
  logic [DEB_W-1:0]     deb_cnt;
  logic                 deb_lvl, deb_lvl_d;
  logic                 step_evt;
  logic [DIV_WIDTH-1:0] presc;
  logic [DIV_WIDTH-1:0] mask;
  logic                 tick;
  logic                 halt_lat;

  // Synchronizers and button debounce; a new level is accepted only after
  // DEB_CYCLES consecutive cycles of disagreement with the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_meta  <= 1'b0;
      run_s     <= 1'b0;
      step_meta <= 1'b0;
      step_s    <= 1'b0;
      deb_cnt   <= '0;
      deb_lvl   <= 1'b0;
      deb_lvl_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // so the two-stage shift below really is two stages.
      run_meta  <= run_sw;
      run_s     <= run_meta;
      step_meta <= step_btn;
      step_s    <= step_meta;
      deb_lvl_d <= deb_lvl;
      if (step_s == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_lvl <= step_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign step_evt = deb_lvl & ~deb_lvl_d;

  always_comb begin
    // NOTE: mask gets a value before the case so no path can leave it unassigned
    // and infer a latch.
    mask = '0;
    case (div_sel)
      2'd1:    mask = DIV_WIDTH'(32'h0000_000F);
      2'd2:    mask = DIV_WIDTH'(32'h0000_03FF);
      2'd3:    mask = {DIV_WIDTH{1'b1}};
      default: mask = '0;
    endcase
  end

  assign tick = ((presc & mask) == mask);

  // Mode FSM with registered enable pulse, prescaler, halt latch and pulse counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HALT;
      cpu_en      <= 1'b0;
      cycle_count <= '0;
      presc       <= '0;
      halt_lat    <= 1'b0;
    end else begin
      cycle_count <= cycle_count + 32'(cpu_en);
      halt_lat    <= halt_req | (halt_lat & run_s);
      cpu_en      <= 1'b0;
      case (state_q)
        ST_HALT: begin
          if (step_evt) begin
            state_q <= ST_STEP;
          end else if (run_s & ~halt_lat & ~halt_req) begin
            state_q <= ST_RUN;
            presc   <= '0;
          end
        end
        ST_RUN: begin
          presc  <= presc + DIV_WIDTH'(1);
          cpu_en <= tick & run_s & ~halt_req;
          if (~run_s | halt_req) state_q <= ST_HALT;
        end
        ST_STEP: begin
          // The step pulse is issued even if the core is requesting a halt.
          cpu_en  <= 1'b1;
          state_q <= ST_HALT;
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: a behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps

module tb_cpu_clk_ctrl;

  localparam int DIV_WIDTH  = 8;
  localparam int DEB_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_sw;
  logic        step_btn;
  logic [1:0]  div_sel;
  logic        halt_req;
  logic        cpu_en;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(
    .DIV_WIDTH  (DIV_WIDTH),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .div_sel     (div_sel),
    .halt_req    (halt_req),
    .cpu_en      (cpu_en),
    .state       (state),
    .cycle_count (cycle_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: inputs seen through a two-edge delay, button accepted after
  // DEB_CYCLES equal samples, run rate from cycles spent in RUN.
  bit [31:0] m_count;
  bit        m_en;
  int        m_state;
  bit        run_d1, run_d2, btn_d1, btn_d2;
  bit        last_btn, acc_lvl, acc_rise, halt_seen;
  int        btn_run, run_age;

  task automatic model_step();
    bit rs, bs, evt, tick, accept;
    int mk, nxt;
    if (rst === 1'b1) begin
      m_count = 0; m_en = 0; m_state = 0;
      run_d1 = 0; run_d2 = 0; btn_d1 = 0; btn_d2 = 0;
      last_btn = 0; acc_lvl = 0; acc_rise = 0; halt_seen = 0;
      btn_run = 0; run_age = 0;
    end else begin
      rs  = run_d2;
      bs  = btn_d2;
      evt = acc_rise;
      case (div_sel)
        2'd0:    mk = 0;
        2'd1:    mk = 15;
        2'd2:    mk = 1023;
        default: mk = (1 << DIV_WIDTH) - 1;
      endcase
      mk   = mk % (1 << DIV_WIDTH);
      tick = (((run_age % (1 << DIV_WIDTH)) & mk) == mk);
      m_count = m_count + 32'(m_en);
      m_en = (m_state == 2) || (m_state == 1 && tick && rs && !halt_req);
      nxt = m_state;
      case (m_state)
        0: begin
          if (evt) nxt = 2;
          else if (rs && !halt_seen && !halt_req) begin
            nxt = 1;
            run_age = 0;
          end
        end
        1: begin
          run_age++;
          if (!rs || halt_req) nxt = 0;
        end
        default: nxt = 0;
      endcase
      m_state   = nxt;
      halt_seen = halt_req || (halt_seen && rs);
      btn_run   = (bs == last_btn) ? btn_run + 1 : 1;
      last_btn  = bs;
      accept    = (bs != acc_lvl) && (btn_run == DEB_CYCLES);
      acc_rise  = accept && bs;
      if (accept) acc_lvl = bs;
      run_d2 = run_d1; run_d1 = run_sw;
      btn_d2 = btn_d1; btn_d1 = step_btn;
    end
  endtask

  // Inputs only change at negedges, so 1 ns after posedge they still hold the sampled values.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      check("model cpu_en", 32'(cpu_en), 32'(m_en));
      check("model state", 32'(state), 32'(m_state));
      check("model cycle_count", cycle_count, m_count);
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpu_en === 1'b1) pulses++;
    end
  endtask

  logic [11:0] bounce;
  bit          found;

  initial begin
    rst = 1'b1; run_sw = 1'b1; step_btn = 1'b1; div_sel = 2'd1; halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset cpu_en", 32'(cpu_en), 0);
      check("reset state", 32'(state), 0);
      check("reset cycle_count", cycle_count, 0);
    end

    // Release reset with run requested at 1/16: RUN after N+2, pulses at N+18, N+34, ...
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 1) check("release state N+1", 32'(state), 0);
      if (k == 2) check("release RUN N+2", 32'(state), 1);
      check("div16 pulse pattern", 32'(cpu_en), 32'(k >= 18 && (k - 18) % 16 == 0));
      if (cpu_en === 1'b1) pulses++;
    end
    check("div16 pulse count", pulses, 12);
    run_sw = 1'b0; step_btn = 1'b0;
    pulses = 0;
    cycles(10);
    check("div16 no pulse after stop", pulses, 0);
    check("div16 cycle_count", cycle_count, 12);
    check("div16 halted", 32'(state), 0);

    // Full rate: enable continuously from N+3.
    div_sel = 2'd0; run_sw = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("full-rate cpu_en", 32'(cpu_en), 32'(k >= 3));
      if (k == 49) check("full-rate count N+49", cycle_count, 58);
    end
    run_sw = 1'b0;
    cycles(10);
    check("full-rate count after stop", cycle_count, 61);

    // Bouncy button: runs of 1-3 cycles never satisfy the debouncer.
    bounce = 12'b1000_1011_1001;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step_btn = bounce[i];
      cycles(1);
    end
    check("bounce no pulse", pulses, 0);
    step_btn = 1'b1;
    cycles(20);
    check("bouncy step one pulse", pulses, 1);
    check("bouncy step count", cycle_count, 62);
    cycles(20);
    check("held button no repeat", pulses, 1);
    step_btn = 1'b0;
    cycles(10);
    step_btn = 1'b1;
    cycles(20);
    check("second press pulse", pulses, 2);
    check("second press count", cycle_count, 63);
    step_btn = 1'b0;
    cycles(10);

    // Halt request in RUN, then latched halt while run_sw stays 1.
    div_sel = 2'd0; run_sw = 1'b1;
    cycles(10);
    check("halt test in RUN", 32'(state), 1);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    check("halt_req cpu_en", 32'(cpu_en), 0);
    check("halt_req state", 32'(state), 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("halt latched", 32'(state), 0);
    end
    pulses = 0;
    step_btn = 1'b1;
    cycles(20);
    check("step while halted", pulses, 1);
    step_btn = 1'b0;
    cycles(10);
    check("still halted after step", 32'(state), 0);
    run_sw = 1'b0;
    cycles(5);
    run_sw = 1'b1;
    cycles(4);
    check("RUN resumes", 32'(state), 1);

    // Reset mid-run at cycle_count 37, then restart timing.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (cycle_count == 37) found = 1'b1;
    end
    check("reach count 37", 32'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid-run reset count", cycle_count, 0);
    check("mid-run reset state", 32'(state), 0);
    check("mid-run reset cpu_en", 32'(cpu_en), 0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post-reset cpu_en", 32'(cpu_en), 32'(k >= 3));
      if (k == 1) check("post-reset state N+1", 32'(state), 0);
      if (k == 2) check("post-reset RUN N+2", 32'(state), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
